// File: rtl/bmp280_spi_responder_if.sv
// SPI pin bundle between an SPI master and the BMP280 responder.
interface bmp280_spi_responder_if;
  logic sclk;
  logic ss_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, ss_n, mosi, input miso, miso_oe);
  modport slave  (input sclk, ss_n, mosi, output miso, miso_oe);
endinterface

// File: rtl/bmp280_spi_responder.sv
// BMP280 SPI-mode-0 register emulator with a forced/normal conversion timer.
// Pin edges act 3 clk later; no backpressure, the SPI master paces every transfer.
module bmp280_spi_responder #(
  parameter logic [7:0] CHIP_ID        = 8'h58,
  parameter int         MEAS_CYCLES    = 64,
  parameter int         STANDBY_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  n_rst,
  bmp280_spi_responder_if.slave spi,
  input  logic [19:0]           press_raw_in,
  input  logic [19:0]           temp_raw_in,
  output logic [7:0]            ctrl_meas_out,
  output logic [7:0]            config_out,
  output logic                  wr_strobe
);
  localparam int CMAX = (MEAS_CYCLES > STANDBY_CYCLES) ? MEAS_CYCLES : STANDBY_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [19:0] RAW_RST = 20'h80000;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_RD, S_WR_DATA, S_WR_CMD} spi_state_t;
  typedef enum logic [1:0] {M_SLEEP, M_MEAS, M_STANDBY} meas_state_t;

  spi_state_t    state_q, state_d;
  meas_state_t   mstate_q, mstate_d;
  logic [2:0]    sclk_sync_q;
  logic [1:0]    ss_sync_q, mosi_sync_q;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    shift_q, shift_d, addr_q, addr_d;
  logic [7:0]    tx_q, tx_d, ctrl_q, ctrl_d, cfg_q, cfg_d;
  logic          miso_q, miso_d, wr_strobe_q;
  logic [19:0]   press_q, press_d, temp_q, temp_d;
  logic [19:0]   press_sh_q, press_sh_d, temp_sh_q, temp_sh_d;
  logic [CW-1:0] mcnt_q, mcnt_d;

  logic       sclk_rise, sclk_fall, ss_hi, mosi_b, rx_state, byte_done;
  logic [7:0] rx_byte;
  logic       wr_fire, ctrl_wr, cfg_wr, rst_wr, soft_rst;
  logic       abort, restart, conv_end, conv_done;
  logic [1:0] mode_w, eff_mode;
  logic       measuring, miso_o, miso_oe_o;

  function automatic logic [7:0] reg_read(input logic [6:0] a, input logic [19:0] p,
                                          input logic [19:0] t, input logic meas,
                                          input logic [7:0] c, input logic [7:0] g);
    case (a)
      7'h50:   reg_read = CHIP_ID;
      7'h73:   reg_read = {4'b0, meas, 3'b0};
      7'h74:   reg_read = c;
      7'h75:   reg_read = g;
      7'h77:   reg_read = p[19:12];
      7'h78:   reg_read = p[11:4];
      7'h79:   reg_read = {p[3:0], 4'h0};
      7'h7A:   reg_read = t[19:12];
      7'h7B:   reg_read = t[11:4];
      7'h7C:   reg_read = {t[3:0], 4'h0};
      default: reg_read = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= 2'b11;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi.sclk};
      ss_sync_q   <= {ss_sync_q[0], spi.ss_n};
      mosi_sync_q <= {mosi_sync_q[0], spi.mosi};
    end
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ss_hi     = ss_sync_q[1];
  assign mosi_b    = mosi_sync_q[1];
  assign rx_state  = (state_q == S_CMD) || (state_q == S_WR_DATA) || (state_q == S_WR_CMD);
  assign byte_done = sclk_rise && !ss_hi && rx_state && (bit_cnt_q == 3'd7);
  assign rx_byte   = {shift_q, mosi_b};
  assign wr_fire   = byte_done && (state_q == S_WR_DATA);
  assign ctrl_wr   = wr_fire && (addr_q == 7'h74);
  assign cfg_wr    = wr_fire && (addr_q == 7'h75);
  assign rst_wr    = wr_fire && (addr_q == 7'h60);
  assign soft_rst  = rst_wr && (rx_byte == 8'hB6);
  assign mode_w    = rx_byte[1:0];
  assign abort     = ctrl_wr && (mode_w == 2'b00);
  assign restart   = ctrl_wr && (mstate_q == M_MEAS) && ((mode_w == 2'b01) || (mode_w == 2'b10));
  assign conv_end  = (mstate_q == M_MEAS) && (mcnt_q == CW'(1));
  // A ctrl_meas write landing on the final conversion cycle takes precedence.
  assign conv_done = conv_end && !soft_rst && !abort && !restart;
  assign eff_mode  = ctrl_wr ? mode_w : ctrl_q[1:0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      mstate_q <= M_SLEEP;
    end else begin
      state_q  <= state_d;
      mstate_q <= mstate_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ss_hi) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_CMD;
        S_CMD:     if (byte_done) state_d = rx_byte[7] ? S_RD : S_WR_DATA;
        S_WR_DATA: if (byte_done) state_d = S_WR_CMD;
        S_WR_CMD:  if (byte_done) state_d = S_WR_DATA;
        default:   ;
      endcase
    end
  end

  always_comb begin
    mstate_d = mstate_q;
    if (soft_rst || abort) begin
      mstate_d = M_SLEEP;
    end else if (ctrl_wr && (mstate_q == M_SLEEP)) begin
      mstate_d = M_MEAS;
    end else if (!restart) begin
      case (mstate_q)
        M_MEAS:    if (conv_end) mstate_d = (eff_mode == 2'b11) ? M_STANDBY : M_SLEEP;
        M_STANDBY: if (mcnt_q == CW'(1)) mstate_d = M_MEAS;
        default:   ;
      endcase
    end
  end

  always_comb begin
    miso_oe_o = (state_q != S_IDLE);
    miso_o    = (state_q == S_RD) ? miso_q : 1'b0;
    measuring = (mstate_q == M_MEAS);
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    press_sh_d = press_sh_q;
    temp_sh_d  = temp_sh_q;
    if (state_q == S_IDLE || ss_hi) begin
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else begin
      if (sclk_rise && rx_state) begin
        shift_d   = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (byte_done && state_q != S_WR_DATA) addr_d = rx_byte[6:0];
      // The whole read burst is served from a snapshot taken at the command byte.
      if (byte_done && state_q == S_CMD && rx_byte[7]) begin
        tx_d       = reg_read(rx_byte[6:0], press_q, temp_q, measuring, ctrl_q, cfg_q);
        press_sh_d = press_q;
        temp_sh_d  = temp_q;
      end
      if (sclk_fall && state_q == S_RD) begin
        miso_d    = tx_q[7];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          addr_d = addr_q + 7'd1;
          tx_d   = reg_read(addr_q + 7'd1, press_sh_q, temp_sh_q, measuring, ctrl_q, cfg_q);
        end else begin
          tx_d = {tx_q[6:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    cfg_d   = cfg_q;
    press_d = press_q;
    temp_d  = temp_q;
    if (soft_rst) begin
      ctrl_d  = '0;
      cfg_d   = '0;
      press_d = RAW_RST;
      temp_d  = RAW_RST;
    end else begin
      if (ctrl_wr)                                      ctrl_d = rx_byte;
      else if (conv_done && ctrl_q[1:0] != 2'b11)      ctrl_d = {ctrl_q[7:2], 2'b00};
      if (cfg_wr)                                       cfg_d  = rx_byte & 8'hFD;
      if (conv_done && ctrl_q[4:2] != 3'd0)             press_d = press_raw_in;
      if (conv_done && ctrl_q[7:5] != 3'd0)             temp_d  = temp_raw_in;
    end
    if (mstate_d == M_SLEEP)                                         mcnt_d = '0;
    else if (mstate_d == M_MEAS && (mstate_q != M_MEAS || restart))  mcnt_d = CW'(MEAS_CYCLES);
    else if (mstate_d == M_STANDBY && mstate_q != M_STANDBY)         mcnt_d = CW'(STANDBY_CYCLES);
    else                                                             mcnt_d = mcnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      ctrl_q      <= '0;
      cfg_q       <= '0;
      press_q     <= RAW_RST;
      temp_q      <= RAW_RST;
      press_sh_q  <= RAW_RST;
      temp_sh_q   <= RAW_RST;
      mcnt_q      <= '0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      wr_strobe_q <= ctrl_wr | cfg_wr | rst_wr;
      ctrl_q      <= ctrl_d;
      cfg_q       <= cfg_d;
      press_q     <= press_d;
      temp_q      <= temp_d;
      press_sh_q  <= press_sh_d;
      temp_sh_q   <= temp_sh_d;
      mcnt_q      <= mcnt_d;
    end
  end

  assign spi.miso      = miso_o;
  assign spi.miso_oe   = miso_oe_o;
  assign ctrl_meas_out = ctrl_q;
  assign config_out    = cfg_q;
  assign wr_strobe     = wr_strobe_q;
endmodule

// File: tb/tb_bmp280_spi_responder.sv
// Bench for bmp280_spi_responder: SPI master stimulus, register-map reference model, miso monitor.
module tb_bmp280_spi_responder;
  localparam int MEAS = 300;
  localparam int STBY = 200;
  localparam int H    = 5;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [19:0] press_raw_in = '0;
  logic [19:0] temp_raw_in = '0;
  logic [7:0]  ctrl_meas_out, config_out;
  logic        wr_strobe;

  bmp280_spi_responder_if spi();

  bmp280_spi_responder #(.CHIP_ID(8'h58), .MEAS_CYCLES(MEAS), .STANDBY_CYCLES(STBY)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .spi          (spi),
    .press_raw_in (press_raw_in),
    .temp_raw_in  (temp_raw_in),
    .ctrl_meas_out(ctrl_meas_out),
    .config_out   (config_out),
    .wr_strobe    (wr_strobe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int strobe_cnt = 0, exp_strobes = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  m_ctrl, m_cfg;
  logic [19:0] m_press, m_temp;
  logic        m_meas;

  always @(posedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] model_reg(input logic [7:0] a);
    case (a)
      8'hD0:   return 8'h58;
      8'hF3:   return m_meas ? 8'h08 : 8'h00;
      8'hF4:   return m_ctrl;
      8'hF5:   return m_cfg;
      8'hF7:   return m_press[19:12];
      8'hF8:   return m_press[11:4];
      8'hF9:   return {m_press[3:0], 4'h0};
      8'hFA:   return m_temp[19:12];
      8'hFB:   return m_temp[11:4];
      8'hFC:   return {m_temp[3:0], 4'h0};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 8'h00; m_cfg = 8'h00; m_press = 20'h80000; m_temp = 20'h80000; m_meas = 1'b0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    case (a)
      8'hF4: begin m_ctrl = d; exp_strobes++; end
      8'hF5: begin m_cfg = d & 8'hFD; exp_strobes++; end
      8'hE0: begin exp_strobes++; if (d == 8'hB6) model_reset(); end
      default: ;
    endcase
  endtask

  // One completed conversion: sample what oversampling enables, forced mode falls back to sleep.
  task automatic model_conv();
    if (m_ctrl[4:2] != 3'd0) m_press = press_raw_in;
    if (m_ctrl[7:5] != 3'd0) m_temp = temp_raw_in;
    if (m_ctrl[1:0] != 2'b11) m_ctrl[1:0] = 2'b00;
  endtask

  task automatic sel();
    spi.ss_n = 1'b0;
    repeat (2*H) @(negedge clk);
  endtask

  task automatic desel();
    repeat (H) @(negedge clk);
    spi.ss_n = 1'b1;
    repeat (2*H) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int nb);
    for (int i = 0; i < nb; i++) begin
      spi.mosi = b[7-i];
      repeat (H) @(negedge clk);
      spi.sclk = 1'b1;
      repeat (H) @(negedge clk);
      spi.sclk = 1'b0;
    end
  endtask

  task automatic spi_read(input logic [7:0] a, input int n);
    logic [7:0] ra;
    ra = a;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(model_reg(ra));
      ra = {1'b1, ra[6:0] + 7'd1};
    end
    sel();
    send({1'b1, a[6:0]}, 8);
    for (int k = 0; k < n; k++) send(8'h00, 8);
    desel();
  endtask

  task automatic spi_write(input logic [7:0] a, input logic [7:0] d);
    sel();
    send({1'b0, a[6:0]}, 8);
    send(d, 8);
    desel();
    model_write(a, d);
  endtask

  // Monitor: decodes each select from the pins and scores every completed read byte.
  initial begin
    logic [7:0] cmd, rx;
    int nb;
    logic rd;
    forever begin
      @(negedge spi.ss_n);
      nb = 0; cmd = '0; rx = '0; rd = 1'b0;
      while (spi.ss_n == 1'b0) begin
        @(posedge spi.sclk or posedge spi.ss_n);
        if (spi.ss_n) break;
        if (nb < 8) cmd = {cmd[6:0], spi.mosi};
        else        rx  = {rx[6:0], spi.miso};
        nb++;
        if (nb == 8) rd = cmd[7];
        if (rd && nb > 8 && (nb % 8) == 0) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL read_byte: got %0h with no expected byte queued (cmd %0h)", rx, cmd);
          end else begin
            check($sformatf("read_byte cmd=%0h idx=%0d", cmd, nb/8 - 2), rx, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v, a;
    spi.ss_n = 1'b1; spi.sclk = 1'b0; spi.mosi = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    check("rst_ctrl_meas", ctrl_meas_out, 8'h00);
    check("rst_config", config_out, 8'h00);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_miso_oe", spi.miso_oe, 1'b0);
    check("rst_miso", spi.miso, 1'b0);
    n_rst = 1'b1;
    repeat (5) @(negedge clk);

    spi_read(8'hD0, 1);
    spi_read(8'hE0, 1);
    check("miso_oe_deselected", spi.miso_oe, 1'b0);
    sel();
    check("miso_oe_selected", spi.miso_oe, 1'b1);
    desel();
    check("miso_oe_after_ss_high", spi.miso_oe, 1'b0);

    // Forced conversion with known samples.
    press_raw_in = 20'hABCDE; temp_raw_in = 20'h12345;
    spi_write(8'hF4, 8'h5D);
    check("ctrl_after_write", ctrl_meas_out, 8'h5D);
    check("strobe_single", strobe_cnt, exp_strobes);
    m_meas = 1'b1;
    spi_read(8'hF3, 1);
    m_meas = 1'b0;
    repeat (MEAS) @(negedge clk);
    model_conv();
    spi_read(8'hF3, 1);
    spi_read(8'hF4, 1);
    check("ctrl_forced_cleared", ctrl_meas_out, 8'h5C);
    spi_read(8'hF7, 6);

    // Write burst, then normal mode must keep converting.
    sel();
    send(8'h74, 8); send(8'h27, 8); send(8'h75, 8); send(8'h90, 8);
    desel();
    model_write(8'hF4, 8'h27); model_write(8'hF5, 8'h90);
    check("burst_ctrl", ctrl_meas_out, 8'h27);
    check("burst_config", config_out, 8'h90);
    check("burst_strobes", strobe_cnt, exp_strobes);
    press_raw_in = 20'h13579; temp_raw_in = 20'h2468A;
    repeat (2*MEAS + STBY) @(negedge clk);
    model_conv();
    spi_read(8'hF7, 6);
    press_raw_in = 20'hFEDCB; temp_raw_in = 20'h0F0F1;
    repeat (MEAS + STBY + 100) @(negedge clk);
    model_conv();
    spi_read(8'hF7, 6);
    spi_write(8'hF4, 8'h24);
    check("normal_stopped", ctrl_meas_out, 8'h24);
    repeat (MEAS + 20) @(negedge clk);
    spi_read(8'hF3, 1);

    // Aborted data byte leaves config untouched.
    sel();
    send(8'h75, 8); send(8'h5A, 5);
    desel();
    check("partial_config", config_out, 8'h90);
    check("partial_strobes", strobe_cnt, exp_strobes);
    spi_read(8'hF5, 1);

    // Randomized forced conversions, including disabled oversampling.
    for (int it = 0; it < 6; it++) begin
      press_raw_in = 20'($urandom); temp_raw_in = 20'($urandom);
      v = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b01};
      spi_write(8'hF4, v);
      repeat (MEAS + 40) @(negedge clk);
      model_conv();
      check("rand_ctrl_after_conv", ctrl_meas_out, m_ctrl);
      spi_read(8'hF7, 6);
    end

    for (int it = 0; it < 4; it++) begin
      v = 8'($urandom);
      spi_write(8'hF5, v);
      check("rand_config", config_out, m_cfg);
      spi_read(8'hF4, 3);
    end
    check("rand_strobes", strobe_cnt, exp_strobes);

    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 3))
        0:       a = 8'hD0;
        1:       a = 8'hF3 + 8'($urandom_range(0, 9));
        2:       a = 8'hFD + 8'($urandom_range(0, 2));
        default: a = {1'b1, 7'($urandom)};
      endcase
      spi_read(a, $urandom_range(1, 4));
    end

    // Soft reset and address wrap.
    spi_write(8'hE0, 8'hB6);
    check("soft_rst_ctrl", ctrl_meas_out, 8'h00);
    check("soft_rst_config", config_out, 8'h00);
    spi_read(8'hF7, 1);
    spi_read(8'hFF, 2);
    spi_read(8'hFC, 6);

    repeat (20) @(negedge clk);
    check("expected_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
